// File: rtl/cond_pkg.sv
// Condition-code and flag-index definitions shared by the branch-condition unit
// and any later compare-and-branch logic.
package cond_pkg;

   localparam logic [3:0] COND_NEVER  = 4'd0;
   localparam logic [3:0] COND_EQ     = 4'd1;
   localparam logic [3:0] COND_LT     = 4'd2;
   localparam logic [3:0] COND_LE     = 4'd3;
   localparam logic [3:0] COND_ALWAYS = 4'd4;
   localparam logic [3:0] COND_NE     = 4'd5;
   localparam logic [3:0] COND_GE     = 4'd6;
   localparam logic [3:0] COND_GT     = 4'd7;
   localparam logic [3:0] COND_LTU    = 4'd8;
   localparam logic [3:0] COND_LEU    = 4'd9;
   localparam logic [3:0] COND_GEU    = 4'd10;
   localparam logic [3:0] COND_GTU    = 4'd11;
   localparam logic [3:0] COND_MI     = 4'd12;
   localparam logic [3:0] COND_PL     = 4'd13;
   localparam logic [3:0] COND_VS     = 4'd14;
   localparam logic [3:0] COND_VC     = 4'd15;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: {V,C,N,Z} flags and a 4-bit condition code
// give a taken/not-taken decision.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [3:0] cond,
   output logic       taken
);

   logic z;
   logic n;
   logic c;
   logic v;
   logic lt;

   always_comb begin
      z  = flags[FLAG_Z];
      n  = flags[FLAG_N];
      c  = flags[FLAG_C];
      v  = flags[FLAG_V];
      lt = n ^ v;
      taken = 1'b0;
      unique case (cond)
         COND_NEVER:  taken = 1'b0;
         COND_EQ:     taken = z;
         COND_LT:     taken = lt;
         COND_LE:     taken = z | lt;
         COND_ALWAYS: taken = 1'b1;
         COND_NE:     taken = !z;
         COND_GE:     taken = !lt;
         COND_GT:     taken = !z & !lt;
         COND_LTU:    taken = c;
         COND_LEU:    taken = c | z;
         COND_GEU:    taken = !c;
         COND_GTU:    taken = !c & !z;
         COND_MI:     taken = n;
         COND_PL:     taken = !n;
         COND_VS:     taken = v;
         COND_VC:     taken = !v;
         default:     taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_branch_unit.sv
// Branch-condition unit: ALU flag register, condition requests via valid/ready,
// registered taken decision with tag, and a saturating taken-branch counter.
module cond_branch_unit
   import cond_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int TAG_W  = 3,
   parameter int FWD    = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flag_we,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   input  logic              alu_ovf,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_cond,
   input  logic              req_src,
   input  logic [DATA_W-1:0] req_operand,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_taken,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [3:0]        flags_q,
   output logic [CNT_W-1:0]  taken_cnt
);

   logic [3:0] new_flags_p0;
   logic [3:0] live_flags_p0;
   logic [3:0] stored_flags_p0;
   logic [3:0] eval_flags_p0;
   logic       taken_p0;
   logic       accept_p0;
   logic       rsp_fire;

   // Stage p0: flag construction, forwarding select and condition evaluation
   always_comb begin
      new_flags_p0         = '0;
      new_flags_p0[FLAG_Z] = (alu_result == '0);
      new_flags_p0[FLAG_N] = alu_result[DATA_W-1];
      new_flags_p0[FLAG_C] = alu_carry;
      new_flags_p0[FLAG_V] = alu_ovf;

      // Live operands carry no carry/overflow information, matching the legacy checker.
      live_flags_p0         = '0;
      live_flags_p0[FLAG_Z] = (req_operand == '0);
      live_flags_p0[FLAG_N] = req_operand[DATA_W-1];

      stored_flags_p0 = (FWD != 0 && flag_we) ? new_flags_p0 : flags_q;
      eval_flags_p0   = req_src ? live_flags_p0 : stored_flags_p0;
   end

   cond_eval u_eval (
      .flags (eval_flags_p0),
      .cond  (req_cond),
      .taken (taken_p0)
   );

   assign req_ready = !rsp_valid || rsp_ready;
   assign accept_p0 = req_valid && req_ready;
   assign rsp_fire  = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flags_q <= '0;
      end else if (flag_we) begin
         flags_q <= new_flags_p0;
      end
   end

   // Stage p1: response register, held while the consumer stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_taken <= 1'b0;
         rsp_tag   <= '0;
      end else if (accept_p0) begin
         rsp_valid <= 1'b1;
         rsp_taken <= taken_p0;
         rsp_tag   <= req_tag;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         taken_cnt <= '0;
      end else if (rsp_fire && rsp_taken && (taken_cnt != '1)) begin
         taken_cnt <= taken_cnt + 1'b1;
      end
   end

endmodule
